// File: rtl/fibonacci_sequencer.sv
// K-order Fibonacci term generator: start/done run control, valid/ready term stream, sticky overflow.
// Optional FIB_SATURATE_EN: clamp overflowing terms to all-ones instead of wrapping.
module fibonacci_sequencer #(
  parameter int          W     = 8,
  parameter int          K     = 2,
  parameter int          NW    = 8,
  parameter int unsigned SEED0 = 0,
  parameter int unsigned SEED1 = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [NW-1:0] i_n_terms,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_term,
  output logic [NW-1:0] o_idx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf
);

  localparam int SW = W + 2;
  localparam logic [SW-1:0] TERM_MAX = {2'b00, {W{1'b1}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;
  logic [NW-1:0] r_idx;
  logic [NW-1:0] r_last;
  // r_hist[0] is the term on the output, r_hist[j] the term j beats earlier
  logic [W-1:0]  r_hist [K];

  logic [SW-1:0] w_part [K+1];
  logic [SW-1:0] w_sum;
  logic          w_sum_ovf;
  logic [W-1:0]  w_sum_term;
  logic          w_first;
  logic [W-1:0]  w_next_term;
  logic          w_next_ovf;

  logic w_accept;
  logic w_is_last;
  logic w_idle_start;
  logic w_launch;
  logic w_advance;
  logic w_finish;

  // Running sum of the last K emitted terms, with two bits of headroom for K<=4
  assign w_part[0] = '0;
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_sum
      assign w_part[gi+1] = w_part[gi] + SW'(r_hist[gi]);
    end
  endgenerate

  assign w_sum     = w_part[K];
  assign w_sum_ovf = (w_sum > TERM_MAX);

`ifdef FIB_SATURATE_EN
  assign w_sum_term = w_sum_ovf ? {W{1'b1}} : w_sum[W-1:0];
`else
  assign w_sum_term = w_sum[W-1:0];
`endif

  // t1 is a seed, not a sum, so the step out of index 0 bypasses the adder
  assign w_first     = (r_idx == '0);
  assign w_next_term = w_first ? W'(SEED1) : w_sum_term;
  assign w_next_ovf  = !w_first && w_sum_ovf;

  always_comb begin
    w_state_next = r_state;
    w_accept     = r_valid & i_ready;
    w_is_last    = (r_idx == r_last);
    w_idle_start = 1'b0;
    w_launch     = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_idle_start = 1'b1;
          if (i_n_terms != '0) begin
            w_launch     = 1'b1;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_is_last) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
      r_last  <= '0;
    end else begin
      // A zero-length request completes immediately with a bare done pulse
      r_done <= w_finish | (w_idle_start & ~w_launch);

      if (w_idle_start) begin
        r_ovf <= 1'b0;
      end else if (w_advance && w_next_ovf) begin
        r_ovf <= 1'b1;
      end

      if (w_launch) begin
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_last  <= i_n_terms - NW'(1);
      end else if (w_advance) begin
        r_idx <= r_idx + NW'(1);
      end else if (w_finish) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  // History shifts only on acceptance, so backpressure freezes the recurrence
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_hist[gi] <= '0;
          end else if (w_launch) begin
            r_hist[gi] <= W'(SEED0);
          end else if (w_advance) begin
            r_hist[gi] <= w_next_term;
          end
        end
      end else begin : g_tail
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_hist[gi] <= '0;
          end else if (w_launch) begin
            r_hist[gi] <= '0;
          end else if (w_advance) begin
            r_hist[gi] <= r_hist[gi-1];
          end
        end
      end
    end
  endgenerate

  assign o_valid = r_valid;
  assign o_term  = r_hist[0];
  assign o_idx   = r_idx;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Scoreboard bench: three sequencers (K=2,3,4) run in lockstep on shared random stimulus,
// each beat checked against an arithmetic reference of the recurrence.
module tb_fibonacci_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n_terms;
  logic       ready;

  logic       w_valid [3];
  logic       w_busy  [3];
  logic       w_done  [3];
  logic       w_ovf   [3];
  logic [7:0] w_term  [3];
  logic [7:0] w_idx   [3];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      fibonacci_sequencer #(
        .W(8), .K(gi + 2), .NW(8), .SEED0(0), .SEED1(1)
      ) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_n_terms(n_terms),
        .o_valid  (w_valid[gi]),
        .i_ready  (ready),
        .o_term   (w_term[gi]),
        .o_idx    (w_idx[gi]),
        .o_busy   (w_busy[gi]),
        .o_done   (w_done[gi]),
        .o_ovf    (w_ovf[gi])
      );
    end
  endgenerate

  typedef struct packed {
    logic [2:0][7:0] term;
    logic [2:0]      ovf;
    logic [7:0]      idx;
    logic            last;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ready_mode = 0;
  bit    start_run = 0;
  bit    zero_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: t0=0, t1=1, t(i)=sum of previous K stored terms (t(<0)=0), sticky ovf per run
  task automatic push_run(input int n);
    beat_t bt [64];
    int    t  [64];
    bit    of;
    for (int kk = 0; kk < 3; kk++) begin
      of = 0;
      for (int i = 0; i < n; i++) begin
        int s;
        if (i == 0) s = 0;
        else if (i == 1) s = 1;
        else begin
          s = 0;
          for (int j = 1; j <= kk + 2; j++) if (i - j >= 0) s += t[i-j];
        end
        if (s > 255) begin
          of = 1;
`ifdef FIB_SATURATE_EN
          t[i] = 255;
`else
          t[i] = s % 256;
`endif
        end else begin
          t[i] = s;
        end
        bt[i].term[kk] = t[i][7:0];
        bt[i].ovf[kk]  = of;
        bt[i].idx      = i[7:0];
        bt[i].last     = (i == n - 1);
      end
    end
    for (int i = 0; i < n; i++) sb_q.push_back(bt[i]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s K%0d valid", tag, i + 2), int'(w_valid[i]), 0);
      chk($sformatf("%s K%0d term",  tag, i + 2), int'(w_term[i]),  0);
      chk($sformatf("%s K%0d idx",   tag, i + 2), int'(w_idx[i]),   0);
      chk($sformatf("%s K%0d busy",  tag, i + 2), int'(w_busy[i]),  0);
      chk($sformatf("%s K%0d done",  tag, i + 2), int'(w_done[i]),  0);
      chk($sformatf("%s K%0d ovf",   tag, i + 2), int'(w_ovf[i]),   0);
    end
  endtask

  // Ready driver: 0 = always high, 1 = 1,0,0 repeating, 2 = random ~70% high
  initial begin
    int pc;
    pc = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       begin ready = (pc % 3 == 0); pc++; end
        default: ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: pops on each accepted beat, checks hold stability, first-beat latency,
  // back-to-back throughput and the done pulse timing
  initial begin
    bit         pend_done;
    bit         pend_valid;
    bit         held;
    bit         nd;
    bit         nv;
    logic [7:0] hold_term [3];
    logic [7:0] hold_idx  [3];
    beat_t      b;
    pend_done = 0; pend_valid = 0; held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 0; pend_valid = 0; held = 0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (w_done[i] || pend_done)
            chk($sformatf("K%0d done", i + 2), int'(w_done[i]), int'(pend_done));
          if (pend_valid)
            chk($sformatf("K%0d valid_next", i + 2), int'(w_valid[i]), 1);
        end
        nd = zero_start;
        nv = start_run;
        if (w_valid[0]) begin
          if (held) begin
            for (int i = 0; i < 3; i++) begin
              chk($sformatf("K%0d hold term", i + 2), int'(w_term[i]), int'(hold_term[i]));
              chk($sformatf("K%0d hold idx",  i + 2), int'(w_idx[i]),  int'(hold_idx[i]));
            end
          end
          if (ready) begin
            held = 0;
            if (sb_q.size() == 0) begin
              chk("unexpected beat idx", int'(w_idx[0]), -1);
            end else begin
              b = sb_q.pop_front();
              for (int i = 0; i < 3; i++) begin
                chk($sformatf("K%0d valid idx%0d", i + 2, b.idx), int'(w_valid[i]), 1);
                chk($sformatf("K%0d term idx%0d",  i + 2, b.idx), int'(w_term[i]),  int'(b.term[i]));
                chk($sformatf("K%0d idx",          i + 2),        int'(w_idx[i]),   int'(b.idx));
                chk($sformatf("K%0d ovf idx%0d",   i + 2, b.idx), int'(w_ovf[i]),   int'(b.ovf[i]));
                chk($sformatf("K%0d busy idx%0d",  i + 2, b.idx), int'(w_busy[i]),  1);
              end
              if (b.last) nd = 1;
              else nv = 1;
            end
          end else begin
            held = 1;
            for (int i = 0; i < 3; i++) begin
              hold_term[i] = w_term[i];
              hold_idx[i]  = w_idx[i];
            end
          end
        end else if (held) begin
          chk("valid dropped without accept", int'(w_valid[0]), 1);
          held = 0;
        end
        pend_done  = nd;
        pend_valid = nv;
      end
    end
  end

  // Issues one run starting at posedge+1; returns at posedge+1 in the done cycle
  task automatic run(input int n, input bit spurious);
    int cyc;
    start      = 1'b1;
    n_terms    = n[7:0];
    start_run  = (n > 0);
    zero_start = (n == 0);
    if (n > 0) push_run(n);
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_run  = 1'b0;
    zero_start = 1'b0;
    if (n == 0) begin
      @(posedge clk);
      #1;
    end else begin
      cyc = 0;
      while (sb_q.size() != 0 && cyc < 2000) begin
        if (spurious && $urandom_range(0, 3) == 0) begin
          start   = 1'b1;
          n_terms = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      start = 1'b0;
      if (cyc >= 2000) begin
        chk($sformatf("run n=%0d timeout, beats left", n), sb_q.size(), 0);
        sb_q.delete();
      end
    end
    $display("run n_terms=%0d ready_mode=%0d spurious=%0d done, compared=%0d mismatched=%0d",
             n, ready_mode, spurious, n_cmp, n_err);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    n_terms = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    ready_mode = 0; run(10, 0);
    ready_mode = 1; run(10, 0);
    ready_mode = 0; run(15, 0);
    run(3, 0);
    run(7, 1);
    run(0, 0);
    run(1, 0);
    ready_mode = 2;
    for (int r = 0; r < 16; r++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      run(n, 1);
    end

    // Asynchronous reset in the middle of a run, then a clean restart
    ready_mode = 0;
    @(posedge clk);
    #1;
    start = 1'b1; n_terms = 8'd12; start_run = 1'b1;
    push_run(12);
    @(posedge clk);
    #1;
    start = 1'b0; start_run = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre-reset idx", int'(w_idx[0]), 5);
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(8, 0);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
